// File: rtl/gf163_pkg.sv
// Purpose: shared constants, state encoding, operand framing and word
//          selection helpers for the GF(2^163) multiplier sequencer.
// Contents: M, W, NW, FRAME_W, FRAME_LSB, TIMEOUT, WCNT_W, G_POLY,
//           state_e, op_frames_t, to_frame(), word_sel().
package gf163_pkg;

    localparam int unsigned M         = 163;
    localparam int unsigned W         = 32;
    localparam int unsigned NW        = 6;
    localparam int unsigned FRAME_W   = 192;
    localparam int unsigned FRAME_LSB = 5;
    localparam int unsigned TIMEOUT   = 64;
    localparam int unsigned WCNT_W    = $clog2(TIMEOUT + 1);

    // Low part of f(x) = x^163 + x^7 + x^6 + x^3 + 1
    localparam logic [M-1:0] G_POLY = 163'hC9;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_WAIT = 3'd2,
        ST_CAPT = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    // Framed operand pair held for the duration of the load phase
    typedef struct packed {
        logic [FRAME_W-1:0] a;
        logic [FRAME_W-1:0] b;
    } op_frames_t;

    // Place an M-bit field element at frame bits [FRAME_LSB +: M], rest zero
    function automatic logic [FRAME_W-1:0] to_frame(input logic [M-1:0] x);
        return FRAME_W'(x) << FRAME_LSB;
    endfunction

    // Word k of a frame, k = 0 is the most significant word; k >= NW yields 0
    function automatic logic [W-1:0] word_sel(input logic [FRAME_W-1:0] f,
                                              input logic [2:0]         k);
        logic [FRAME_W-1:0] sh;
        sh = f << (W * 32'(k));
        return sh[FRAME_W-1 -: W];
    endfunction

endpackage

// File: rtl/gf163_frame_slicer.sv
// Purpose: combinational selection of one 32-bit word from a 192-bit frame.
// Ports:
//   frame_i  in  FRAME_W  source frame
//   idx_i    in  3        word index, 0 = MSW; indices >= NW give 0
//   word_c   out W        selected word (combinational)
module gf163_frame_slicer
    import gf163_pkg::*;
(
    input  logic [FRAME_W-1:0] frame_i,
    input  logic [2:0]         idx_i,
    output logic [W-1:0]       word_c
);

    always_comb word_c = word_sel(frame_i, idx_i);

endmodule

// File: rtl/gf163_mul_sequencer.sv
// Purpose: command-level controller for the 32-bit word-serial GF(2^163)
//          multiplier core. Takes an operand pair, streams A/B/G words on
//          the core's input schedule, captures the six result words and
//          returns the 163-bit product, with a timeout / dropped-ctro error.
// Ports:
//   clk, rstn                 clock, async active-low reset
//   cmd_valid/cmd_ready       command handshake, cmd_a/cmd_b operands
//   res_valid/res_ready       result handshake, res_p product, res_err error
//   mul_ctr/mul_a/mul_b/mul_g core inputs (registered)
//   mul_po/mul_ctro           core result word and result-valid
module gf163_mul_sequencer
    import gf163_pkg::*;
(
    input  logic         clk,
    input  logic         rstn,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [M-1:0] cmd_a,
    input  logic [M-1:0] cmd_b,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [M-1:0] res_p,
    output logic         res_err,
    output logic         mul_ctr,
    output logic [W-1:0] mul_a,
    output logic [W-1:0] mul_b,
    output logic [W-1:0] mul_g,
    input  logic [W-1:0] mul_po,
    input  logic         mul_ctro
);

    localparam logic [FRAME_W-1:0] G_FRAME = to_frame(G_POLY);

    state_e              state_q, state_d;
    logic [2:0]          t_q, t_d;
    logic [2:0]          i_q, i_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    op_frames_t          frm_q, frm_d;
    logic [FRAME_W-1:0]  cap_q, cap_d;

    logic                cmd_ready_q, cmd_ready_d;
    logic                res_valid_q, res_valid_d;
    logic [M-1:0]        res_p_q, res_p_d;
    logic                res_err_q, res_err_d;
    logic                mul_ctr_q, mul_ctr_d;
    logic [W-1:0]        mul_a_q, mul_a_d;
    logic [W-1:0]        mul_b_q, mul_b_d;
    logic [W-1:0]        mul_g_q, mul_g_d;

    logic [FRAME_W-1:0]  b_src;
    logic [2:0]          idx_ag;
    logic [W-1:0]        a_word, b_word, g_word;
    logic [FRAME_W-1:0]  cap_shift;

    // B word 0 leaves on the accept edge, so it is sliced from the live command
    assign b_src     = (state_q == ST_IDLE) ? to_frame(cmd_b) : frm_q.b;
    // A and G trail B by one slot
    assign idx_ag    = t_d - 3'd1;
    assign cap_shift = {cap_q[FRAME_W-W-1:0], mul_po};

    gf163_frame_slicer u_slice_a (.frame_i(frm_q.a), .idx_i(idx_ag), .word_c(a_word));
    gf163_frame_slicer u_slice_b (.frame_i(b_src),   .idx_i(t_d),    .word_c(b_word));
    gf163_frame_slicer u_slice_g (.frame_i(G_FRAME), .idx_i(idx_ag), .word_c(g_word));

    // Next state, counters and capture register
    always_comb begin
        state_d   = state_q;
        t_d       = t_q;
        i_d       = i_q;
        wcnt_d    = wcnt_q;
        frm_d     = frm_q;
        cap_d     = cap_q;
        res_p_d   = res_p_q;
        res_err_d = res_err_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    state_d = ST_LOAD;
                    t_d     = 3'd0;
                    frm_d.a = to_frame(cmd_a);
                    frm_d.b = to_frame(cmd_b);
                end
            end
            ST_LOAD: begin
                if (t_q == 3'd7) begin
                    state_d = ST_WAIT;
                    wcnt_d  = '0;
                end else begin
                    t_d = t_q + 3'd1;
                end
            end
            ST_WAIT: begin
                if (mul_ctro) begin
                    cap_d   = cap_shift;
                    i_d     = 3'd1;
                    state_d = ST_CAPT;
                end else begin
                    wcnt_d = wcnt_q + WCNT_W'(1);
                    if (wcnt_d == WCNT_W'(TIMEOUT)) begin
                        state_d   = ST_DONE;
                        res_err_d = 1'b1;
                        res_p_d   = '0;
                    end
                end
            end
            ST_CAPT: begin
                if (mul_ctro) begin
                    cap_d = cap_shift;
                    if (i_q == 3'(NW - 1)) begin
                        state_d   = ST_DONE;
                        res_p_d   = cap_shift[FRAME_LSB +: M];
                        res_err_d = 1'b0;
                    end else begin
                        i_d = i_q + 3'd1;
                    end
                end else begin
                    // Result stream broke before the last word
                    state_d   = ST_DONE;
                    res_err_d = 1'b1;
                    res_p_d   = '0;
                end
            end
            ST_DONE: begin
                if (res_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Registered outputs decoded from the state/slot being entered
    always_comb begin
        cmd_ready_d = (state_d == ST_IDLE);
        res_valid_d = (state_d == ST_DONE);
        mul_ctr_d   = 1'b0;
        mul_a_d     = '0;
        mul_b_d     = '0;
        mul_g_d     = '0;
        if (state_d == ST_LOAD) begin
            mul_ctr_d = (t_d != 3'd0);
            if (t_d <= 3'(NW - 1)) mul_b_d = b_word;
            if (t_d >= 3'd1 && t_d <= 3'(NW)) begin
                mul_a_d = a_word;
                mul_g_d = g_word;
            end
        end else if (state_d == ST_WAIT || state_d == ST_CAPT) begin
            mul_ctr_d = 1'b1;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            t_q         <= '0;
            i_q         <= '0;
            wcnt_q      <= '0;
            frm_q       <= '0;
            cap_q       <= '0;
            cmd_ready_q <= 1'b1;
            res_valid_q <= 1'b0;
            res_p_q     <= '0;
            res_err_q   <= 1'b0;
            mul_ctr_q   <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            mul_g_q     <= '0;
        end else begin
            state_q     <= state_d;
            t_q         <= t_d;
            i_q         <= i_d;
            wcnt_q      <= wcnt_d;
            frm_q       <= frm_d;
            cap_q       <= cap_d;
            cmd_ready_q <= cmd_ready_d;
            res_valid_q <= res_valid_d;
            res_p_q     <= res_p_d;
            res_err_q   <= res_err_d;
            mul_ctr_q   <= mul_ctr_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            mul_g_q     <= mul_g_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign res_valid = res_valid_q;
    assign res_p     = res_p_q;
    assign res_err   = res_err_q;
    assign mul_ctr   = mul_ctr_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign mul_g     = mul_g_q;

endmodule

// File: tb/tb_gf163_mul_sequencer.sv
// Purpose: self-checking bench for gf163_mul_sequencer with a behavioural
//          word-serial core model (normal, silent, and drop-after-3 modes).
module tb_gf163_mul_sequencer;

    localparam int LAT_NORMAL  = 16;
    localparam int LAT_TIMEOUT = 8 + 64;
    localparam logic [162:0] POLY = 163'hC9;

    logic         clk = 1'b0;
    logic         rstn;
    logic         cmd_valid, cmd_ready;
    logic [162:0] cmd_a, cmd_b;
    logic         res_valid, res_ready, res_err;
    logic [162:0] res_p;
    logic         mul_ctr;
    logic [31:0]  mul_a, mul_b, mul_g, mul_po;
    logic         mul_ctro;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int acc_cyc = 0;
    int mode   = 0;   // core model: 0 normal, 1 never ctro, 2 drop after 3 words

    gf163_mul_sequencer dut (
        .clk(clk), .rstn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_p(res_p), .res_err(res_err),
        .mul_ctr(mul_ctr), .mul_a(mul_a), .mul_b(mul_b), .mul_g(mul_g),
        .mul_po(mul_po), .mul_ctro(mul_ctro)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Polynomial product mod x^163 + g(x), bit-serial Horner form
    function automatic logic [162:0] gf_mul(input logic [162:0] a, input logic [162:0] b,
                                            input logic [162:0] g);
        logic [162:0] r;
        logic         c;
        r = '0;
        for (int i = 162; i >= 0; i--) begin
            c = r[162];
            r = r << 1;
            if (c) r = r ^ g;
            if (b[i]) r = r ^ a;
        end
        return r;
    endfunction

    function automatic logic [162:0] rand163();
        logic [191:0] v;
        v = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return v[162:0];
    endfunction

    task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Core model: collects B0 in the ctr=0 slot, then 6 ctr=1 slots of A/B/G,
    // and streams the product frame back a fixed delay later.
    int          col_n = 0, sc = 0, emit_idx = 6, emit_lim = 6;
    logic        prev_ctr = 1'b0;
    logic [31:0] prev_b = '0;
    logic [31:0] aw [6];
    logic [31:0] bw [6];
    logic [31:0] gw [6];
    logic [31:0] rw [6];

    always @(negedge clk) begin
        logic [191:0] fa, fb, fg, fr;
        if (!rstn) begin
            col_n = 0; sc = 0; emit_idx = 6; emit_lim = 6;
            prev_ctr = 1'b0; prev_b = '0;
            mul_ctro = 1'b0; mul_po = '0;
        end else begin
            if (sc > 0) begin
                sc--;
                if (sc == 0) begin
                    emit_idx = 0;
                    emit_lim = (mode == 1) ? 0 : (mode == 2) ? 3 : 6;
                end
            end
            if (emit_idx < emit_lim) begin
                mul_ctro = 1'b1; mul_po = rw[emit_idx]; emit_idx++;
            end else begin
                mul_ctro = 1'b0; mul_po = '0;
            end
            if (col_n == 0 && !prev_ctr && mul_ctr) begin
                bw[0] = prev_b;
                col_n = 1;
            end
            if (col_n >= 1) begin
                if (col_n <= 5) bw[col_n] = mul_b;
                aw[col_n-1] = mul_a;
                gw[col_n-1] = mul_g;
                col_n++;
                if (col_n == 7) begin
                    fa = {aw[0], aw[1], aw[2], aw[3], aw[4], aw[5]};
                    fb = {bw[0], bw[1], bw[2], bw[3], bw[4], bw[5]};
                    fg = {gw[0], gw[1], gw[2], gw[3], gw[4], gw[5]};
                    fr = {24'b0, gf_mul(fa[167:5], fb[167:5], fg[167:5]), 5'b0};
                    for (int k = 0; k < 6; k++) rw[k] = 32'(fr >> (32 * (5 - k)));
                    col_n = 0;
                    sc    = 4;
                end
            end
            prev_ctr = mul_ctr;
            prev_b   = mul_b;
        end
    end

    // Offer a command and return in the first LOAD slot (t0)
    task automatic issue(input logic [162:0] a, input logic [162:0] b, input bit keep);
        int n;
        n = 0;
        cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
        while (!cmd_ready && n < 400) begin @(negedge clk); n++; end
        if (!cmd_ready) check("cmd_ready_wait", 0, 1);
        @(negedge clk);
        acc_cyc = cyc;
        if (!keep) cmd_valid = 1'b0;
    endtask

    task automatic get_result(input int hold, output logic [162:0] p, output logic e,
                              output int lat);
        int n;
        bit rdy_seen;
        n = 0; rdy_seen = 0; p = '0; e = 1'b0; lat = -1;
        while (!res_valid && n < 400) begin
            if (cmd_ready) rdy_seen = 1;
            @(negedge clk); n++;
        end
        check("cmd_ready_busy", 192'(rdy_seen), 0);
        if (!res_valid) begin
            check("res_valid_wait", 0, 1);
        end else begin
            lat = cyc - acc_cyc;
            p = res_p; e = res_err;
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                check("hold_valid", 192'(res_valid), 1);
                check("hold_p", res_p, p);
            end
            res_ready = 1'b1;
            @(negedge clk);
            res_ready = 1'b0;
            check("valid_clear", 192'(res_valid), 0);
            check("idle_ready", 192'(cmd_ready), 1);
        end
    endtask

    task automatic run_op(input string tag, input logic [162:0] a, input logic [162:0] b,
                          input int hold, input bit keep);
        logic [162:0] p;
        logic         e;
        int           lat;
        issue(a, b, keep);
        get_result(hold, p, e, lat);
        check({tag, "_p"}, p, gf_mul(a, b, POLY));
        check({tag, "_err"}, 192'(e), 0);
        check({tag, "_lat"}, 192'(lat), 192'(LAT_NORMAL));
    endtask

    initial begin
        logic [31:0]  g_exp [8];
        logic [162:0] p, ra, rb;
        logic         e;
        int           lat;
        bit           saw;

        rstn = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; res_ready = 1'b0;
        #12;
        check("rst_cmd_ready", 192'(cmd_ready), 1);
        check("rst_res_valid", 192'(res_valid), 0);
        check("rst_mul", {mul_ctr, mul_a, mul_b, mul_g}, 0);
        check("rst_res", {res_err, res_p}, 0);
        @(negedge clk); rstn = 1'b1;
        @(negedge clk);

        // 1: A=B=1, with G word schedule
        g_exp = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0000_1920, 32'h0};
        issue(163'd1, 163'd1, 0);
        for (int s = 0; s < 8; s++) begin
            check($sformatf("g_slot%0d", s), 192'(mul_g), 192'(g_exp[s]));
            check($sformatf("ctr_slot%0d", s), 192'(mul_ctr), 192'(s != 0));
            if (s < 7) @(negedge clk);
        end
        get_result(0, p, e, lat);
        check("one_p", p, 1);
        check("one_err", 192'(e), 0);
        check("one_lat", 192'(lat), 192'(LAT_NORMAL));

        // 2: reduction boundary, plain product, result hold
        run_op("x162_x", 163'd1 << 162, 163'd2, 0, 0);
        issue(163'd1 << 162, 163'd2, 0);
        get_result(0, p, e, lat);
        check("x163_literal", p, 163'hC9);
        run_op("x100_x50", 163'd1 << 100, 163'd1 << 50, 5, 0);
        @(negedge clk);
        check("x150_p_held", res_p, 163'd1 << 150);

        // 3: back-to-back with cmd_valid held high
        for (int j = 0; j < 3; j++) begin
            ra = rand163(); rb = rand163();
            run_op($sformatf("b2b%0d", j), ra, rb, 0, j < 2);
        end

        // 4: core never answers
        mode = 1;
        issue(rand163(), rand163(), 0);
        get_result(0, p, e, lat);
        check("tmo_err", 192'(e), 1);
        check("tmo_p", p, 0);
        check("tmo_lat", 192'(lat), 192'(LAT_TIMEOUT));

        // 5: core drops ctro after 3 words, then normal operation
        mode = 2;
        issue(rand163(), rand163(), 0);
        get_result(0, p, e, lat);
        check("drop_err", 192'(e), 1);
        check("drop_p", p, 0);
        mode = 0;
        run_op("after_drop", rand163(), rand163(), 0, 0);

        // 6: reset during LOAD t=3
        ra = rand163() | (163'd1 << 160); rb = rand163() | (163'd1 << 150);
        issue(ra, rb, 0);
        repeat (3) @(negedge clk);
        rstn = 1'b0;
        #1;
        check("arst_mul", {mul_ctr, mul_a, mul_b, mul_g}, 0);
        check("arst_ready", 192'(cmd_ready), 1);
        check("arst_valid", 192'(res_valid), 0);
        @(negedge clk); @(negedge clk);
        rstn = 1'b1;
        saw = 0;
        repeat (30) begin @(negedge clk); if (res_valid) saw = 1; end
        check("arst_no_valid", 192'(saw), 0);
        run_op("after_rst", rand163(), rand163(), 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
